// File: rtl/int_pkg.sv
// Shared widths and the priority-encoder helper for the interrupt register.
package int_pkg;
  localparam int N_SRC = 4;
  localparam int ID_W  = 2;

  // Lowest set index wins; returns 0 when nothing is set.
  function automatic logic [ID_W-1:0] prio_id(input logic [N_SRC-1:0] act);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = N_SRC-1; i >= 0; i--)
      if (act[i]) id = ID_W'(i);
    return id;
  endfunction
endpackage

// File: rtl/interrupt_register_if.sv
// Software/control-unit side of the interrupt register: mask write, ack, status.
interface interrupt_register_if;
  import int_pkg::*;

  logic             Write;
  logic [N_SRC-1:0] WData;
  logic             Ack;
  logic [N_SRC-1:0] Pending;
  logic [N_SRC-1:0] Enable;
  logic             IRQ;
  logic [ID_W-1:0]  IntID;

  modport master (output Write, WData, Ack,
                  input  Pending, Enable, IRQ, IntID);
  modport slave  (input  Write, WData, Ack,
                  output Pending, Enable, IRQ, IntID);
endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus a history flop; rise pulses for one cycle on 0->1.
module sync_edge_detect (
  input  logic CLK,
  input  logic CLR,
  input  logic async_in,
  output logic rise
);
  logic s1, s2, prev;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= async_in;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign rise = s2 & ~prev;
endmodule

// File: rtl/interrupt_register.sv
// Four-source interrupt capture: edge-latched pending bits, enable mask,
// fixed priority (source 0 highest) and ack-to-clear.
module interrupt_register
  import int_pkg::*;
(
  input  logic CLK,
  input  logic CLR,
  input  logic Sw0,
  input  logic Sw1,
  input  logic Sw2,
  input  logic Sw3,
  interrupt_register_if.slave bus
);
  logic [N_SRC-1:0] sw, rise, pending_q, enable_q, active, ack_mask;
  logic             irq;
  logic [ID_W-1:0]  int_id;

  assign sw = {Sw3, Sw2, Sw1, Sw0};

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    sync_edge_detect u_sed (
      .CLK      (CLK),
      .CLR      (CLR),
      .async_in (sw[g]),
      .rise     (rise[g])
    );
  end

  assign active = pending_q & enable_q;
  assign irq    = |active;
  assign int_id = prio_id(active);

  // Ack only ever targets the source currently presented; a no-IRQ ack is a no-op.
  always_comb begin
    ack_mask = '0;
    if (bus.Ack && irq) ack_mask[int_id] = 1'b1;
  end

  // Set has priority over clear so a fresh edge is never lost to a concurrent ack.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      pending_q <= '0;
      enable_q  <= '0;
    end else begin
      pending_q <= (pending_q & ~ack_mask) | rise;
      if (bus.Write) enable_q <= bus.WData;
    end
  end

  assign bus.Pending = pending_q;
  assign bus.Enable  = enable_q;
  assign bus.IRQ     = irq;
  assign bus.IntID   = int_id;
endmodule

// File: tb/tb_interrupt_register.sv
// Scoreboarded bench: each task queues expected {Pending,Enable,IRQ,IntID} and checks it.
module tb_interrupt_register;
  typedef logic [10:0] word_t; // {Pending[3:0], Enable[3:0], IRQ, IntID[1:0]}

  logic CLK, CLR, Sw0, Sw1, Sw2, Sw3;
  interrupt_register_if bus();

  interrupt_register dut (
    .CLK (CLK), .CLR (CLR),
    .Sw0 (Sw0), .Sw1 (Sw1), .Sw2 (Sw2), .Sw3 (Sw3),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  word_t sb[$];
  int    n_cmp = 0;
  int    n_err = 0;

  function automatic word_t mk(input logic [3:0] p, input logic [3:0] e,
                               input logic irq, input logic [1:0] id);
    return {p, e, irq, id};
  endfunction

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_write(input logic [3:0] v);
    bus.Write = 1'b1; bus.WData = v;
    tick(1);
    bus.Write = 1'b0;
  endtask

  task automatic do_ack();
    bus.Ack = 1'b1;
    tick(1);
    bus.Ack = 1'b0;
  endtask

  task automatic test_reset();
    word_t exp, obs;
    CLR = 1'b0; Sw0 = 0; Sw1 = 0; Sw2 = 0; Sw3 = 0;
    bus.Write = 0; bus.WData = '0; bus.Ack = 0;
    sb.push_back(mk(4'b0000, 4'b0000, 1'b0, 2'd0));
    #100;
    exp = sb.pop_front();
    obs = {bus.Pending, bus.Enable, bus.IRQ, bus.IntID};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL reset: got %b want %b", obs, exp); end
    @(negedge CLK); CLR = 1'b1;
    tick(1);
  endtask

  task automatic test_masked_capture();
    word_t exp, obs;
    Sw2 = 1'b1;
    sb.push_back(mk(4'b0000, 4'b0000, 1'b0, 2'd0)); // two edges: not yet pending
    sb.push_back(mk(4'b0100, 4'b0000, 1'b0, 2'd0)); // third edge: pending, masked
    sb.push_back(mk(4'b0100, 4'b1111, 1'b1, 2'd2)); // mask opened
    sb.push_back(mk(4'b0000, 4'b1111, 1'b0, 2'd0)); // acked; Sw2 still high
    tick(2);
    exp = sb.pop_front(); obs = {bus.Pending, bus.Enable, bus.IRQ, bus.IntID}; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL masked_latency: got %b want %b", obs, exp); end
    tick(1);
    exp = sb.pop_front(); obs = {bus.Pending, bus.Enable, bus.IRQ, bus.IntID}; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL masked_pending: got %b want %b", obs, exp); end
    do_write(4'b1111);
    exp = sb.pop_front(); obs = {bus.Pending, bus.Enable, bus.IRQ, bus.IntID}; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL masked_enable: got %b want %b", obs, exp); end
    do_ack();
    tick(3);
    exp = sb.pop_front(); obs = {bus.Pending, bus.Enable, bus.IRQ, bus.IntID}; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL masked_ack_hold: got %b want %b", obs, exp); end
    Sw2 = 1'b0;
    tick(3);
  endtask

  task automatic test_priority_ack();
    word_t exp, obs;
    Sw1 = 1'b1; Sw3 = 1'b1;
    sb.push_back(mk(4'b1010, 4'b1111, 1'b1, 2'd1));
    sb.push_back(mk(4'b1000, 4'b1111, 1'b1, 2'd3));
    sb.push_back(mk(4'b0000, 4'b1111, 1'b0, 2'd0));
    tick(3);
    exp = sb.pop_front(); obs = {bus.Pending, bus.Enable, bus.IRQ, bus.IntID}; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL prio_capture: got %b want %b", obs, exp); end
    do_ack();
    exp = sb.pop_front(); obs = {bus.Pending, bus.Enable, bus.IRQ, bus.IntID}; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL prio_ack1: got %b want %b", obs, exp); end
    do_ack();
    exp = sb.pop_front(); obs = {bus.Pending, bus.Enable, bus.IRQ, bus.IntID}; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL prio_ack2: got %b want %b", obs, exp); end
    Sw1 = 1'b0; Sw3 = 1'b0;
    tick(3);
  endtask

  task automatic test_level_falling();
    word_t exp, obs;
    Sw0 = 1'b1;
    tick(3);
    do_ack();
    sb.push_back(mk(4'b0000, 4'b1111, 1'b0, 2'd0)); // held high: nothing new
    sb.push_back(mk(4'b0000, 4'b1111, 1'b0, 2'd0)); // falling edge: nothing
    sb.push_back(mk(4'b0001, 4'b1111, 1'b1, 2'd0)); // re-raise: event
    tick(5);
    exp = sb.pop_front(); obs = {bus.Pending, bus.Enable, bus.IRQ, bus.IntID}; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL level_hold: got %b want %b", obs, exp); end
    Sw0 = 1'b0;
    tick(4);
    exp = sb.pop_front(); obs = {bus.Pending, bus.Enable, bus.IRQ, bus.IntID}; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL level_fall: got %b want %b", obs, exp); end
    Sw0 = 1'b1;
    tick(3);
    exp = sb.pop_front(); obs = {bus.Pending, bus.Enable, bus.IRQ, bus.IntID}; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL level_rerise: got %b want %b", obs, exp); end
  endtask

  task automatic test_set_ack_collision();
    word_t exp, obs;
    // Pending[0] is already 1 from the previous task; rearm the edge detector.
    Sw0 = 1'b0;
    tick(3);
    Sw0 = 1'b1;
    tick(2);            // rise[0] is high during the coming cycle
    sb.push_back(mk(4'b0001, 4'b1111, 1'b1, 2'd0));
    do_ack();
    exp = sb.pop_front(); obs = {bus.Pending, bus.Enable, bus.IRQ, bus.IntID}; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL set_beats_ack: got %b want %b", obs, exp); end
  endtask

  task automatic test_ack_without_irq();
    word_t exp, obs;
    do_write(4'b0000);
    sb.push_back(mk(4'b0001, 4'b0000, 1'b0, 2'd0)); // ack with IRQ=0 ignored
    sb.push_back(mk(4'b0001, 4'b1111, 1'b1, 2'd0)); // write+ack: ack sees old mask
    sb.push_back(mk(4'b0000, 4'b1111, 1'b0, 2'd0));
    do_ack();
    exp = sb.pop_front(); obs = {bus.Pending, bus.Enable, bus.IRQ, bus.IntID}; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL ack_no_irq: got %b want %b", obs, exp); end
    bus.Write = 1'b1; bus.WData = 4'b1111; bus.Ack = 1'b1;
    tick(1);
    bus.Write = 1'b0; bus.Ack = 1'b0;
    exp = sb.pop_front(); obs = {bus.Pending, bus.Enable, bus.IRQ, bus.IntID}; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL write_ack_same: got %b want %b", obs, exp); end
    do_ack();
    exp = sb.pop_front(); obs = {bus.Pending, bus.Enable, bus.IRQ, bus.IntID}; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL ack_after_write: got %b want %b", obs, exp); end
  endtask

  task automatic test_async_reset();
    word_t exp, obs;
    Sw0 = 0; Sw1 = 0; Sw2 = 0; Sw3 = 0;
    tick(3);
    Sw0 = 1; Sw1 = 1; Sw2 = 1; Sw3 = 1;
    sb.push_back(mk(4'b1111, 4'b1111, 1'b1, 2'd0));
    sb.push_back(mk(4'b0000, 4'b0000, 1'b0, 2'd0));
    tick(3);
    exp = sb.pop_front(); obs = {bus.Pending, bus.Enable, bus.IRQ, bus.IntID}; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL all_pending: got %b want %b", obs, exp); end
    #2 CLR = 1'b0;      // mid-cycle, well before the next rising edge
    #1;
    exp = sb.pop_front(); obs = {bus.Pending, bus.Enable, bus.IRQ, bus.IntID}; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL async_reset: got %b want %b", obs, exp); end
    tick(2);
    @(negedge CLK); CLR = 1'b1;
    // Switches still high across reset release: exactly one event each.
    sb.push_back(mk(4'b1111, 4'b0000, 1'b0, 2'd0));
    tick(6);
    exp = sb.pop_front(); obs = {bus.Pending, bus.Enable, bus.IRQ, bus.IntID}; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL held_through_reset: got %b want %b", obs, exp); end
  endtask

  initial begin
    test_reset();
    test_masked_capture();
    test_priority_ack();
    test_level_falling();
    test_set_ack_collision();
    test_ack_without_irq();
    test_async_reset();
    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
